cmd_ctrl_burst: RTL and testbench
=================================

# cmd_ctrl_burst

Parametrised frame-driven system controller: decodes command frames arriving from the UART RX path, drives register-file reads and writes (single and burst) and ALU operations, and pushes responses into the TX async FIFO. Sits between the RX data synchroniser, register file, gated-clock ALU and TX FIFO. It is the successor of the fixed 8-bit controller, adding:
- generic widths;
- burst transfers with address auto-increment;
- multi-frame ALU results;
- inter-frame timeout;
- error reporting.

## Interface
- DATA_W, 8, frame/register width
- ADDR_W, 4, register-file address width
- ALU_W, 16, ALU result width; must be a multiple of DATA_W
- FUN_W, 4, ALU function width
- OPA_ADDR, 0, register holding ALU operand A
- OPB_ADDR, 1, register holding ALU operand B
- TIMEOUT, 1023, idle cycles allowed between frames of one command (≥1)

Ports. Reset RST, asynchronous, active-low; clock CLK.
- CLK  in  1  system clock
- RST  in  1  async active-low reset
- RX_p_data  in  DATA_W  received frame
- RX_d_valid  in  1  one-cycle strobe, RX_p_data valid
- Rd_data  in  DATA_W  register-file read data
- RdData_valid  in  1  read data strobe
- ALU_OUT  in  ALU_W  ALU result
- OUT_VALID  in  1  ALU result strobe
- FIFO_full  in  1  TX FIFO full
- ALU_EN  out  1  ALU start
- ALU_FUN  out  FUN_W  ALU function
- CLK_EN  out  1  ALU clock-gate enable
- Address  out  ADDR_W  register-file address
- WrEN  out  1  write pulse
- RdEN  out  1  read pulse
- WrData  out  DATA_W  write data
- TX_p_data  out  DATA_W  response frame
- TX_d_valid  out  1  FIFO push strobe
- busy  out  1  command in progress (state ≠ IDLE)
- err  out  1  one-cycle pulse on bad opcode or timeout

## Operation
- All outputs are registered; every output resets to 0.

Opcodes (first frame of a command):
- 0xAA write: ADDR, DATA.
- 0xBB read: ADDR.
- 0xCC ALU with operands: A, B, FUN.
- 0xDD ALU on stored operands: FUN.
- 0xEE burst write: ADDR, N, then N DATA frames.
- 0xFF burst read: ADDR, N.

Error and abort rules:
- Any other opcode: err pulse, stay IDLE.
- N=0 ends the command with no access and no response.

States: IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, READ_REQ, READ_WAIT, GET_A, GET_B, GET_FUN, ALU_RUN, TX_PUSH.

Writes:
- Each accepted data frame latches WrData and issues a WrEN pulse the next cycle at Address.
- For 0xCC, A is written to OPA_ADDR and B to OPB_ADDR this way.

Reads:
- RdEN pulse, then hold in READ_WAIT until RdData_valid.
- Capture Rd_data, then go to TX_PUSH.

Bursts:
- Address increments after each access and wraps from 2^ADDR_W−1 to 0.
- The down-counter reloads from N; the command ends when it reaches 0.
- A burst read alternates READ_REQ → READ_WAIT → TX_PUSH per word.

ALU:
- ALU_FUN is latched from the FUN frame.
- CLK_EN asserts from GET_FUN acceptance until the result is captured.
- ALU_EN is high throughout ALU_RUN.
- The result is captured on OUT_VALID and sent as ALU_W/DATA_W frames, LSB frame first.

TX_PUSH:
- TX_d_valid is asserted for exactly one cycle per frame, only while FIFO_full=0.
- While FIFO_full=1 the controller holds with no push and no data loss.

Timeout:
- A counter clears on every accepted frame.
- If it reaches TIMEOUT in any GET_* state: err pulse, return to IDLE, no partial write.
- The counter is not running in READ_WAIT, ALU_RUN or TX_PUSH.

## Timing
- Opcode accepted in IDLE on RX_d_valid; the next state applies on the following edge.
- Write: WrEN is high in cycle k+1 for a data frame accepted in cycle k.
- Read: RdEN at k+1; with RdData_valid at k+2, TX_d_valid is at k+3 if the FIFO is not full.
- ALU: first TX_d_valid is one cycle after OUT_VALID; later frames are on consecutive non-full cycles.
- RX_d_valid arriving outside GET_* states is ignored; no buffering.
- Reset mid-command: immediate return to IDLE; pulses drop within the reset assertion.

## Structure
- Package cmd_ctrl_pkg holds:
  - the opcode constants (0xAA–0xFF);
  - the state enumeration;
  - the frames-per-result helper function ALU_W/DATA_W.
- One sub-module, cmd_timeout_cnt: a clear/enable counter with a terminal pulse, width $clog2(TIMEOUT+1).

## Test plan
- AA, 0x05, 0x3C → single WrEN at Address=5, WrData=0x3C; no TX frame.
- BB, 0x05; Rd_data=0x3C after 2 cycles → RdEN once; TX_p_data=0x3C with one TX_d_valid.
- EE, 0x0E, 3, 0x11, 0x22, 0x33 → writes at addresses 14, 15, 0 (wrap).
- Then FF, 0x0E, 3 with FIFO_full toggling → frames 0x11, 0x22, 0x33 in order, no duplicates.
- CC, 0x10, 0x20, FUN=2; ALU_OUT=0x0200 → writes to addresses 0 and 1; CLK_EN and ALU_EN asserted; TX frames 0x00 then 0x02.
- AA, 0x03, then silence for TIMEOUT cycles → err pulse, IDLE, no WrEN.
- Opcode 0x55 → err pulse, busy stays 0.

Source files
------------

// File: rtl/cmd_ctrl_pkg.sv
// Shared definitions for the frame-driven command controller: opcodes,
// FSM state encoding and response framing helpers.
package cmd_ctrl_pkg;

  localparam logic [7:0] OP_WRITE     = 8'hAA;
  localparam logic [7:0] OP_READ      = 8'hBB;
  localparam logic [7:0] OP_ALU       = 8'hCC;
  localparam logic [7:0] OP_ALU_STORE = 8'hDD;
  localparam logic [7:0] OP_BWRITE    = 8'hEE;
  localparam logic [7:0] OP_BREAD     = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_CNT,
    GET_DATA,
    WRITE,
    READ_REQ,
    READ_WAIT,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    TX_PUSH
  } state_e;

  typedef enum logic [2:0] {
    CMD_WR,
    CMD_RD,
    CMD_ALU,
    CMD_ALU_ST,
    CMD_BWR,
    CMD_BRD
  } cmd_e;

  // Number of TX frames needed to carry one ALU result.
  function automatic int frames_per_result(input int alu_w, input int data_w);
    return alu_w / data_w;
  endfunction

  // States that wait for an RX frame and are therefore subject to timeout.
  function automatic logic is_get(input state_e s);
    return s inside {GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN};
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-frame idle counter: clears on demand, counts while enabled and
// flags the terminal count TIMEOUT, where it stops.
module cmd_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = (cnt_q == CNT_W'(TIMEOUT));

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)             cnt_q <= '0;
    else if (clr)         cnt_q <= '0;
    else if (en && !tc)   cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/cmd_ctrl_burst.sv
// Frame-driven system controller: decodes RX command frames into register
// file single/burst accesses and ALU operations, returning results to TX.
module cmd_ctrl_burst
  import cmd_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ALU_W    = 16,
  parameter int FUN_W    = 4,
  parameter int OPA_ADDR = 0,
  parameter int OPB_ADDR = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_p_data,
  input  logic              RX_d_valid,
  input  logic [DATA_W-1:0] Rd_data,
  input  logic              RdData_valid,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              OUT_VALID,
  input  logic              FIFO_full,
  output logic              ALU_EN,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              CLK_EN,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEN,
  output logic              RdEN,
  output logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] TX_p_data,
  output logic              TX_d_valid,
  output logic              busy,
  output logic              err
);

  localparam int NFRM  = frames_per_result(ALU_W, DATA_W);
  localparam int FRM_W = $clog2(NFRM + 1);

  state_e            state_q, state_d;
  cmd_e              cmd_q, cmd_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [ALU_W-1:0]  res_q, res_d, res_shift;
  logic [FRM_W-1:0]  tx_idx_q, tx_idx_d, tx_frames_q, tx_frames_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wr_data_d, tx_data_d;
  logic [FUN_W-1:0]  alu_fun_d;
  logic              wr_en_d, rd_en_d, tx_valid_d, err_d, alu_en_d, clk_en_d;
  logic              tmo_en, tmo_clr, tmo_tc;

  assign tmo_en  = is_get(state_q);
  assign tmo_clr = RX_d_valid || !tmo_en;

  cmd_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK (CLK),
    .RST (RST),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  assign res_shift = res_q >> (tx_idx_q * DATA_W);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    tx_idx_d    = tx_idx_q;
    tx_frames_d = tx_frames_q;
    addr_d      = Address;
    wr_data_d   = WrData;
    tx_data_d   = TX_p_data;
    alu_fun_d   = ALU_FUN;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tx_valid_d  = 1'b0;
    err_d       = 1'b0;
    alu_en_d    = 1'b0;
    clk_en_d    = 1'b0;

    unique case (state_q)
      IDLE: if (RX_d_valid) begin
        if (RX_p_data == DATA_W'(OP_WRITE)) begin
          cmd_d = CMD_WR;  state_d = GET_ADDR;
        end else if (RX_p_data == DATA_W'(OP_READ)) begin
          cmd_d = CMD_RD;  state_d = GET_ADDR;
        end else if (RX_p_data == DATA_W'(OP_ALU)) begin
          // Two operand writes: cnt tracks which one is pending.
          cmd_d = CMD_ALU; cnt_d = DATA_W'(2);
          addr_d = ADDR_W'(OPA_ADDR); state_d = GET_A;
        end else if (RX_p_data == DATA_W'(OP_ALU_STORE)) begin
          cmd_d = CMD_ALU_ST; state_d = GET_FUN;
        end else if (RX_p_data == DATA_W'(OP_BWRITE)) begin
          cmd_d = CMD_BWR; state_d = GET_ADDR;
        end else if (RX_p_data == DATA_W'(OP_BREAD)) begin
          cmd_d = CMD_BRD; state_d = GET_ADDR;
        end else begin
          err_d = 1'b1;
        end
      end

      GET_ADDR: if (RX_d_valid) begin
        addr_d = ADDR_W'(RX_p_data);
        cnt_d  = DATA_W'(1);
        case (cmd_q)
          CMD_WR:  state_d = GET_DATA;
          CMD_RD:  begin rd_en_d = 1'b1; state_d = READ_REQ; end
          default: state_d = GET_CNT;
        endcase
      end else if (tmo_tc) begin
        err_d = 1'b1; state_d = IDLE;
      end

      GET_CNT: if (RX_d_valid) begin
        cnt_d = RX_p_data;
        if (RX_p_data == '0)          state_d = IDLE;
        else if (cmd_q == CMD_BRD)    begin rd_en_d = 1'b1; state_d = READ_REQ; end
        else                          state_d = GET_DATA;
      end else if (tmo_tc) begin
        err_d = 1'b1; state_d = IDLE;
      end

      GET_DATA, GET_A, GET_B: if (RX_d_valid) begin
        wr_data_d = RX_p_data;
        wr_en_d   = 1'b1;
        state_d   = WRITE;
      end else if (tmo_tc) begin
        err_d = 1'b1; state_d = IDLE;
      end

      WRITE: begin
        cnt_d = cnt_q - 1'b1;
        if (cmd_q == CMD_ALU) begin
          addr_d  = ADDR_W'(OPB_ADDR);
          state_d = (cnt_q > DATA_W'(1)) ? GET_B : GET_FUN;
        end else begin
          addr_d  = Address + 1'b1;
          state_d = (cnt_q > DATA_W'(1)) ? GET_DATA : IDLE;
        end
      end

      READ_REQ: state_d = READ_WAIT;

      READ_WAIT: if (RdData_valid) begin
        // First frame goes out on the capture edge to save a cycle.
        res_d       = ALU_W'(Rd_data);
        tx_frames_d = FRM_W'(1);
        tx_idx_d    = '0;
        state_d     = TX_PUSH;
        if (!FIFO_full) begin
          tx_valid_d = 1'b1; tx_data_d = Rd_data; tx_idx_d = FRM_W'(1);
        end
      end

      GET_FUN: if (RX_d_valid) begin
        alu_fun_d = FUN_W'(RX_p_data);
        alu_en_d  = 1'b1;
        clk_en_d  = 1'b1;
        state_d   = ALU_RUN;
      end else if (tmo_tc) begin
        err_d = 1'b1; state_d = IDLE;
      end

      ALU_RUN: begin
        alu_en_d = 1'b1;
        clk_en_d = 1'b1;
        if (OUT_VALID) begin
          alu_en_d    = 1'b0;
          clk_en_d    = 1'b0;
          res_d       = ALU_OUT;
          tx_frames_d = FRM_W'(NFRM);
          tx_idx_d    = '0;
          state_d     = TX_PUSH;
          if (!FIFO_full) begin
            tx_valid_d = 1'b1; tx_data_d = ALU_OUT[DATA_W-1:0]; tx_idx_d = FRM_W'(1);
          end
        end
      end

      TX_PUSH: begin
        if (tx_idx_q == tx_frames_q) begin
          if (cmd_q == CMD_BRD && cnt_q > DATA_W'(1)) begin
            cnt_d   = cnt_q - 1'b1;
            addr_d  = Address + 1'b1;
            rd_en_d = 1'b1;
            state_d = READ_REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (!FIFO_full) begin
          tx_valid_d = 1'b1;
          tx_data_d  = res_shift[DATA_W-1:0];
          tx_idx_d   = tx_idx_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_WR;
      cnt_q       <= '0;
      res_q       <= '0;
      tx_idx_q    <= '0;
      tx_frames_q <= '0;
      Address     <= '0;
      WrData      <= '0;
      TX_p_data   <= '0;
      ALU_FUN     <= '0;
      WrEN        <= 1'b0;
      RdEN        <= 1'b0;
      TX_d_valid  <= 1'b0;
      err         <= 1'b0;
      ALU_EN      <= 1'b0;
      CLK_EN      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      tx_idx_q    <= tx_idx_d;
      tx_frames_q <= tx_frames_d;
      Address     <= addr_d;
      WrData      <= wr_data_d;
      TX_p_data   <= tx_data_d;
      ALU_FUN     <= alu_fun_d;
      WrEN        <= wr_en_d;
      RdEN        <= rd_en_d;
      TX_d_valid  <= tx_valid_d;
      err         <= err_d;
      ALU_EN      <= alu_en_d;
      CLK_EN      <= clk_en_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_cmd_ctrl_burst.sv
// Scoreboard bench for cmd_ctrl_burst: models the register file and FIFO
// backpressure, and checks writes, reads and TX frames against expectations.
module tb_cmd_ctrl_burst;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int ALU_W   = 16;
  localparam int FUN_W   = 4;
  localparam int TIMEOUT = 20;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [DATA_W-1:0] RX_p_data = '0;
  logic              RX_d_valid = 1'b0;
  logic [DATA_W-1:0] Rd_data = '0;
  logic              RdData_valid = 1'b0;
  logic [ALU_W-1:0]  ALU_OUT = '0;
  logic              OUT_VALID = 1'b0;
  logic              FIFO_full = 1'b0;
  logic              ALU_EN, CLK_EN, WrEN, RdEN, TX_d_valid, busy, err;
  logic [FUN_W-1:0]  ALU_FUN;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WrData, TX_p_data;

  cmd_ctrl_burst #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALU_W(ALU_W), .FUN_W(FUN_W),
    .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_p_data(RX_p_data), .RX_d_valid(RX_d_valid),
    .Rd_data(Rd_data), .RdData_valid(RdData_valid), .ALU_OUT(ALU_OUT),
    .OUT_VALID(OUT_VALID), .FIFO_full(FIFO_full), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .Address(Address), .WrEN(WrEN),
    .RdEN(RdEN), .WrData(WrData), .TX_p_data(TX_p_data),
    .TX_d_valid(TX_d_valid), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wr_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  logic [DATA_W-1:0] tx_q[$];
  int                tx_cycs[$];
  logic [DATA_W-1:0] mem [1<<ADDR_W];

  int   n_checks = 0, n_fail = 0;
  int   wr_events = 0, rd_events = 0, err_events = 0;
  int   wren_cyc = 0, rden_cyc = 0, err_cyc = 0, sent_cyc = 0;
  logic prev_full = 1'b0, busy_seen = 1'b0, full_rand = 1'b0;

  // Output monitor: pops the scoreboards on every strobe.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      if (WrEN) begin
        wr_t e;
        wr_events++; wren_cyc = cyc; n_checks++;
        if (wr_q.size() == 0) begin
          n_fail++; $display("FAIL wr_unexpected got addr=%0d data=%h", Address, WrData);
        end else begin
          e = wr_q.pop_front();
          if (Address !== e.addr || WrData !== e.data) begin
            n_fail++;
            $display("FAIL wr_data got addr=%0d data=%h exp addr=%0d data=%h", Address, WrData, e.addr, e.data);
          end
        end
        mem[Address] = WrData;
      end
      if (RdEN) begin
        logic [ADDR_W-1:0] a;
        rd_events++; rden_cyc = cyc; n_checks++;
        if (rd_q.size() == 0) begin
          n_fail++; $display("FAIL rd_unexpected got addr=%0d", Address);
        end else begin
          a = rd_q.pop_front();
          if (Address !== a) begin
            n_fail++; $display("FAIL rd_addr got %0d exp %0d", Address, a);
          end
        end
      end
      if (TX_d_valid) begin
        logic [DATA_W-1:0] d;
        tx_cycs.push_back(cyc);
        n_checks++;
        if (prev_full !== 1'b0) begin
          n_fail++; $display("FAIL tx_while_full got push with FIFO_full=%b exp no push", prev_full);
        end
        n_checks++;
        if (tx_q.size() == 0) begin
          n_fail++; $display("FAIL tx_unexpected got %h", TX_p_data);
        end else begin
          d = tx_q.pop_front();
          if (TX_p_data !== d) begin
            n_fail++; $display("FAIL tx_data got %h exp %h", TX_p_data, d);
          end
        end
      end
      if (err) begin err_events++; err_cyc = cyc; end
      if (busy) busy_seen = 1'b1;
    end
    prev_full = FIFO_full;
  end

  // Register-file read responder: data valid one cycle after RdEN.
  initial forever begin
    @(negedge CLK);
    if (RdEN === 1'b1) begin
      @(posedge CLK); #1;
      Rd_data = mem[Address]; RdData_valid = 1'b1;
      @(posedge CLK); #1;
      RdData_valid = 1'b0;
    end
  end

  // FIFO backpressure generator.
  initial forever begin
    @(posedge CLK); #1;
    FIFO_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [DATA_W-1:0] b, input int gap = 3);
    @(posedge CLK); #1;
    RX_p_data = b; RX_d_valid = 1'b1; sent_cyc = cyc;
    @(posedge CLK); #1;
    RX_d_valid = 1'b0;
    repeat (gap) @(posedge CLK);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
      @(negedge CLK); n++;
    end
    n_checks++;
    if (busy || tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_done got busy=%b pending wr=%0d rd=%0d tx=%0d exp idle", name, busy, wr_q.size(), rd_q.size(), tx_q.size());
    end
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    repeat (3) @(negedge CLK);
    outs = {ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData, TX_p_data, TX_d_valid, busy, err};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0", outs); end
    @(posedge CLK); #1; RST = 1'b1;
    repeat (2) @(negedge CLK);
    outs = {ALU_EN, ALU_FUN, CLK_EN, Address, WrEN, RdEN, WrData, TX_p_data, TX_d_valid, busy, err};
    n_checks++;
    if (outs !== '0) begin n_fail++; $display("FAIL post_reset_outputs got %h exp 0", outs); end
  endtask

  task automatic test_write();
    int tx0 = tx_cycs.size(), w0 = wr_events, dcyc;
    wr_q.push_back('{addr: 4'd5, data: 8'h3C});
    send_frame(8'hAA); send_frame(8'h05); send_frame(8'h3C);
    dcyc = sent_cyc;
    wait_done("write", 50);
    n_checks++;
    if (wr_events - w0 != 1) begin n_fail++; $display("FAIL write_count got %0d exp 1", wr_events - w0); end
    n_checks++;
    if (wren_cyc != dcyc + 1) begin n_fail++; $display("FAIL write_latency got %0d exp 1", wren_cyc - dcyc); end
    n_checks++;
    if (tx_cycs.size() != tx0) begin n_fail++; $display("FAIL write_no_tx got %0d exp 0", tx_cycs.size() - tx0); end
  endtask

  task automatic test_read();
    int tx0 = tx_cycs.size(), r0 = rd_events, acyc;
    rd_q.push_back(4'd5);
    tx_q.push_back(8'h3C);
    send_frame(8'hBB); send_frame(8'h05);
    acyc = sent_cyc;
    wait_done("read", 50);
    n_checks++;
    if (rd_events - r0 != 1) begin n_fail++; $display("FAIL read_count got %0d exp 1", rd_events - r0); end
    n_checks++;
    if (rden_cyc != acyc + 1) begin n_fail++; $display("FAIL read_rden_latency got %0d exp 1", rden_cyc - acyc); end
    n_checks++;
    if (tx_cycs.size() - tx0 != 1 || tx_cycs[tx_cycs.size()-1] != acyc + 3) begin
      n_fail++; $display("FAIL read_tx_latency got frames=%0d last=%0d exp frames=1 latency=3",
                         tx_cycs.size() - tx0, tx_cycs[tx_cycs.size()-1] - acyc);
    end
  endtask

  task automatic test_burst_write();
    int w0 = wr_events;
    wr_q.push_back('{addr: 4'd14, data: 8'h11});
    wr_q.push_back('{addr: 4'd15, data: 8'h22});
    wr_q.push_back('{addr: 4'd0,  data: 8'h33});
    send_frame(8'hEE); send_frame(8'h0E); send_frame(8'h03);
    send_frame(8'h11); send_frame(8'h22); send_frame(8'h33);
    wait_done("burst_write", 50);
    n_checks++;
    if (wr_events - w0 != 3) begin n_fail++; $display("FAIL burst_write_count got %0d exp 3", wr_events - w0); end
  endtask

  task automatic test_burst_read();
    int tx0 = tx_cycs.size(), r0 = rd_events;
    rd_q.push_back(4'd14); rd_q.push_back(4'd15); rd_q.push_back(4'd0);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    full_rand = 1'b1;
    send_frame(8'hFF); send_frame(8'h0E); send_frame(8'h03, 0);
    wait_done("burst_read", 300);
    full_rand = 1'b0;
    n_checks++;
    if (tx_cycs.size() - tx0 != 3 || rd_events - r0 != 3) begin
      n_fail++; $display("FAIL burst_read_count got tx=%0d rd=%0d exp 3/3", tx_cycs.size() - tx0, rd_events - r0);
    end
  endtask

  task automatic test_alu();
    int tx0 = tx_cycs.size(), n = 0, vcyc;
    wr_q.push_back('{addr: 4'd0, data: 8'h10});
    wr_q.push_back('{addr: 4'd1, data: 8'h20});
    tx_q.push_back(8'h00); tx_q.push_back(8'h02);
    send_frame(8'hCC); send_frame(8'h10); send_frame(8'h20); send_frame(8'h02, 0);
    while (ALU_EN !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    n_checks++;
    if (ALU_EN !== 1'b1 || CLK_EN !== 1'b1 || ALU_FUN !== 4'd2) begin
      n_fail++; $display("FAIL alu_start got en=%b clk_en=%b fun=%0d exp 1/1/2", ALU_EN, CLK_EN, ALU_FUN);
    end
    repeat (2) @(posedge CLK);
    #1; OUT_VALID = 1'b1; ALU_OUT = 16'h0200; vcyc = cyc;
    @(negedge CLK);
    n_checks++;
    if (ALU_EN !== 1'b1 || CLK_EN !== 1'b1) begin
      n_fail++; $display("FAIL alu_hold got en=%b clk_en=%b exp 1/1", ALU_EN, CLK_EN);
    end
    @(posedge CLK); #1; OUT_VALID = 1'b0;
    wait_done("alu", 50);
    n_checks++;
    if (tx_cycs.size() - tx0 != 2 || tx_cycs[tx0] != vcyc + 1 || tx_cycs[tx0+1] != vcyc + 2) begin
      n_fail++; $display("FAIL alu_tx_timing got frames=%0d exp 2 at +1,+2", tx_cycs.size() - tx0);
    end
    n_checks++;
    if (CLK_EN !== 1'b0 || ALU_EN !== 1'b0) begin
      n_fail++; $display("FAIL alu_release got en=%b clk_en=%b exp 0/0", ALU_EN, CLK_EN);
    end
  endtask

  task automatic test_timeout();
    int w0 = wr_events, e0 = err_events, c;
    send_frame(8'hAA); send_frame(8'h03, 0);
    c = sent_cyc;
    while (err_events == e0 && cyc - c < TIMEOUT + 10) @(negedge CLK);
    repeat (2) @(negedge CLK);
    n_checks++;
    if (err_events - e0 != 1 || err_cyc - c != TIMEOUT + 2) begin
      n_fail++; $display("FAIL timeout_err got pulses=%0d at %0d exp 1 at %0d", err_events - e0, err_cyc - c, TIMEOUT + 2);
    end
    n_checks++;
    if (busy !== 1'b0 || wr_events != w0) begin
      n_fail++; $display("FAIL timeout_abort got busy=%b writes=%0d exp 0/0", busy, wr_events - w0);
    end
  endtask

  task automatic test_bad_opcode();
    int e0 = err_events;
    busy_seen = 1'b0;
    send_frame(8'h55, 5);
    n_checks++;
    if (err_events - e0 != 1 || busy_seen !== 1'b0) begin
      n_fail++; $display("FAIL bad_opcode got err=%0d busy_seen=%b exp 1/0", err_events - e0, busy_seen);
    end
  endtask

  task automatic test_zero_count();
    int w0 = wr_events, t0 = tx_cycs.size();
    send_frame(8'hEE); send_frame(8'h03); send_frame(8'h00);
    wait_done("zero_count", 20);
    n_checks++;
    if (wr_events != w0 || tx_cycs.size() != t0) begin
      n_fail++; $display("FAIL zero_count got writes=%0d tx=%0d exp 0/0", wr_events - w0, tx_cycs.size() - t0);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_events;
    send_frame(8'hAA); send_frame(8'h07, 0);
    #1; RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (busy !== 1'b0 || WrEN !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got busy=%b wren=%b exp 0/0", busy, WrEN);
    end
    @(posedge CLK); #1; RST = 1'b1;
    send_frame(8'h5A, 5);
    n_checks++;
    if (wr_events != w0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after got writes=%0d busy=%b exp 0/0", wr_events - w0, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    test_reset();
    test_write();
    test_read();
    test_burst_write();
    test_burst_read();
    test_alu();
    test_timeout();
    test_bad_opcode();
    test_zero_count();
    test_reset_mid();
    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || tx_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got wr=%0d rd=%0d tx=%0d exp 0", wr_q.size(), rd_q.size(), tx_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
